fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage for the 16-bit core.
- Holds the program counter and requests 16-bit instructions from a single-cycle instruction cache.
- Presents each fetched instruction with its PC to decode.
- Redirects on resolved branches using an 8-entry branch target buffer (BTB) with FIFO replacement; a BTB hit overrides the target supplied with the branch.

Parameters:
- BTB_DEPTH, 8, number of BTB entries (power of two); FIFO pointer width is log2(BTB_DEPTH).
- PC_STEP, 2, PC increment per accepted instruction (16-bit instructions, byte addressed).

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- branch_type_oi  input  1  reserved branch-type hint; ignored by this revision.
- icache_valid_i  input  1  icache_instr_i holds a valid instruction for icache_pc_o this cycle.
- icache_instr_i  input  16  instruction returned by the icache.
- icache_rd_o  output  1  fetch request to the icache.
- icache_pc_o  output  16  fetch address.
- fetch_valid_i  input  1  downstream enables fetching this cycle.
- instr_valid_o  output  1  fetch_pc_o/fetch_instr_o describe a valid instruction.
- fetch_pc_o  output  16  PC of the presented instruction.
- fetch_instr_o  output  16  presented instruction.
- branch_valid_i  input  1  resolved taken branch this cycle.
- fetch_branch_pc_i  input  16  resolved branch target.
- opcode_pc_i  input  16  PC of the branch instruction (BTB key).

Behaviour:
- State:
  - pc_q (16 bit).
  - BTB arrays tag[BTB_DEPTH], target[BTB_DEPTH] (16 bit each) with valid bits.
  - FIFO write pointer wr_ptr.
  - Output registers fetch_pc_o, fetch_instr_o, instr_valid_o.
- Combinational:
  - icache_pc_o = pc_q.
  - icache_rd_o = fetch_valid_i & ~rst_i & ~branch_valid_i.
  - The icache answers in the same cycle via icache_valid_i / icache_instr_i.
- BTB lookup (combinational on opcode_pc_i): hit if any valid entry has tag == opcode_pc_i. With multiple matches the lowest index wins; this cannot occur, because hits never allocate.
- Reset (rst_i=1 at a clock edge):
  - pc_q=0.
  - All BTB valid bits=0, wr_ptr=0.
  - fetch_pc_o=0, fetch_instr_o=0, instr_valid_o=0.
  - Reset overrides all other inputs, including mid-operation.
- Priority at each edge, highest first:
  - 1) Reset.
  - 2) branch_valid_i=1:
    - On BTB hit: pc_q <= stored target; fetch_branch_pc_i is ignored; BTB unchanged.
    - On miss: pc_q <= fetch_branch_pc_i; entry[wr_ptr] <= {opcode_pc_i, fetch_branch_pc_i, valid}; wr_ptr <= wr_ptr+1, wrapping BTB_DEPTH-1 -> 0. The oldest entry is overwritten once the table is full.
    - In both cases instr_valid_o <= 0 (in-flight fetch flushed), and fetch_pc_o/fetch_instr_o hold.
  - 3) fetch_valid_i=1 and icache_valid_i=1: fetch_pc_o <= pc_q; fetch_instr_o <= icache_instr_i; instr_valid_o <= 1; pc_q <= pc_q + PC_STEP.
  - 4) fetch_valid_i=1 and icache_valid_i=0 (miss/stall): fetch_pc_o <= pc_q; instr_valid_o <= 0; pc_q holds; fetch_instr_o holds its previous value.
  - 5) fetch_valid_i=0: instr_valid_o <= 0; everything else holds.
- Latency: one cycle from a hit request to a valid output. The first instruction after a branch redirect appears two edges after branch_valid_i.
- PC arithmetic is modulo 2^16; 0xFFFE + 2 wraps to 0x0000.
- fetch_instr_o is don't-care whenever instr_valid_o=0; the bench must not check it then.
- Back-to-back branches are allowed every cycle; each is processed independently, and the last one determines pc_q.

Test Plan:
- Sequential fetch: reset, then fetch_valid_i=icache_valid_i=1 with instrs A55A, 5AA5, 1234 on successive edges -> outputs (0000,A55A,1), (0002,5AA5,1), (0004,1234,1); icache_pc_o steps 0,2,4,6.
- Branch miss and allocate: branch opcode_pc 1002 -> target 2000, then fetch CAFE -> instr_valid_o=0 in the branch cycle; next output (2000,CAFE,1).
- BTB hit override: same opcode_pc 1002 with fetch_branch_pc_i=3000 -> pc_q=2000 (stored target); next output (2000,CAFE,1) then (2002,next,1).
- FIFO replacement: after reset, allocate 8 branches (3000+i*100 -> 4000+i*100, i=0..7), then 7000->8000 (evicts 3000), then 7000 with target 9000 -> PC 8000; then 3000 with target 5555 -> miss, PC 5555; fetch BABE -> (5555,BABE,1).
- Cache miss: at PC 8002, icache_valid_i=0 -> (8002,-,0) with pc_q held; then icache_valid_i=1, instr FACE -> (8002,FACE,1), pc_q=8004.
- Reset mid-stream and idle: assert rst_i during fetching -> next edge all outputs 0, pc_q 0, BTB empty (previous opcode_pc re-branch misses). Also fetch_valid_i=0 -> instr_valid_o=0, icache_rd_o=0, PC holds.

Source files
------------

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with PC, icache request and FIFO-replaced BTB redirect
module fetch_unit #(
    parameter int BTB_DEPTH = 8,
    parameter int PC_STEP   = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        branch_type_oi,
    input  logic        icache_valid_i,
    input  logic [15:0] icache_instr_i,
    output logic        icache_rd_o,
    output logic [15:0] icache_pc_o,
    input  logic        fetch_valid_i,
    output logic        instr_valid_o,
    output logic [15:0] fetch_pc_o,
    output logic [15:0] fetch_instr_o,
    input  logic        branch_valid_i,
    input  logic [15:0] fetch_branch_pc_i,
    input  logic [15:0] opcode_pc_i
);

    localparam int PTR_W = $clog2(BTB_DEPTH);

    logic [15:0]          r_pc;
    logic [15:0]          r_tag    [BTB_DEPTH];
    logic [15:0]          r_target [BTB_DEPTH];
    logic [BTB_DEPTH-1:0] r_btb_valid;
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [15:0]          r_fetch_pc;
    logic [15:0]          r_fetch_instr;
    logic                 r_instr_valid;

    logic                 w_hit;
    logic [15:0]          w_hit_target;
    logic                 w_unused_branch_type;

    // The branch-type hint is reserved for a later revision of the predictor.
    assign w_unused_branch_type = branch_type_oi;

    assign icache_pc_o   = r_pc;
    assign icache_rd_o   = fetch_valid_i & ~rst_i & ~branch_valid_i;
    assign fetch_pc_o    = r_fetch_pc;
    assign fetch_instr_o = r_fetch_instr;
    assign instr_valid_o = r_instr_valid;

    // BTB lookup on the branch PC; scanning downward leaves the lowest matching index in place.
    always_comb begin
        w_hit        = 1'b0;
        w_hit_target = 16'h0000;
        for (int i = BTB_DEPTH - 1; i >= 0; i--) begin
            if (r_btb_valid[i] && (r_tag[i] == opcode_pc_i)) begin
                w_hit        = 1'b1;
                w_hit_target = r_target[i];
            end
        end
    end

    // PC, output register and BTB update: reset, then branch redirect, then fetch.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pc          <= 16'h0000;
            r_btb_valid   <= '0;
            r_wr_ptr      <= '0;
            r_fetch_pc    <= 16'h0000;
            r_fetch_instr <= 16'h0000;
            r_instr_valid <= 1'b0;
        end else if (branch_valid_i) begin
            // Any fetch in flight this cycle belongs to the wrong path.
            r_instr_valid <= 1'b0;
            if (w_hit) begin
                r_pc <= w_hit_target;
            end else begin
                r_pc                 <= fetch_branch_pc_i;
                r_tag[r_wr_ptr]      <= opcode_pc_i;
                r_target[r_wr_ptr]   <= fetch_branch_pc_i;
                r_btb_valid[r_wr_ptr] <= 1'b1;
                r_wr_ptr             <= r_wr_ptr + PTR_W'(1);
            end
        end else if (fetch_valid_i) begin
            r_fetch_pc <= r_pc;
            if (icache_valid_i) begin
                r_fetch_instr <= icache_instr_i;
                r_instr_valid <= 1'b1;
                r_pc          <= r_pc + 16'(PC_STEP);
            end else begin
                r_instr_valid <= 1'b0;
            end
        end else begin
            r_instr_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed vector bench for fetch_unit
module tb_fetch_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        branch_type_oi;
    logic        icache_valid_i;
    logic [15:0] icache_instr_i;
    logic        icache_rd_o;
    logic [15:0] icache_pc_o;
    logic        fetch_valid_i;
    logic        instr_valid_o;
    logic [15:0] fetch_pc_o;
    logic [15:0] fetch_instr_o;
    logic        branch_valid_i;
    logic [15:0] fetch_branch_pc_i;
    logic [15:0] opcode_pc_i;

    int n_checks = 0;
    int n_errors = 0;

    fetch_unit #(.BTB_DEPTH(8), .PC_STEP(2)) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .branch_type_oi    (branch_type_oi),
        .icache_valid_i    (icache_valid_i),
        .icache_instr_i    (icache_instr_i),
        .icache_rd_o       (icache_rd_o),
        .icache_pc_o       (icache_pc_o),
        .fetch_valid_i     (fetch_valid_i),
        .instr_valid_o     (instr_valid_o),
        .fetch_pc_o        (fetch_pc_o),
        .fetch_instr_o     (fetch_instr_o),
        .branch_valid_i    (branch_valid_i),
        .fetch_branch_pc_i (fetch_branch_pc_i),
        .opcode_pc_i       (opcode_pc_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        rst;
        logic        fv;
        logic        iv;
        logic [15:0] instr;
        logic        bv;
        logic [15:0] bpc;
        logic [15:0] opc;
        logic [15:0] exp_icpc;
        logic        exp_rd;
        logic        exp_v;
        logic [15:0] exp_fpc;
        logic [15:0] exp_instr;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic rst, logic fv, logic iv, logic [15:0] instr,
                                logic bv, logic [15:0] bpc, logic [15:0] opc,
                                logic [15:0] icpc, logic rd, logic v,
                                logic [15:0] fpc, logic [15:0] finstr);
        vec_t t;
        t.rst = rst; t.fv = fv; t.iv = iv; t.instr = instr;
        t.bv = bv; t.bpc = bpc; t.opc = opc;
        t.exp_icpc = icpc; t.exp_rd = rd; t.exp_v = v;
        t.exp_fpc = fpc; t.exp_instr = finstr;
        vecs.push_back(t);
    endfunction

    task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic fv, input logic iv, input logic [15:0] instr,
                         input logic bv, input logic [15:0] bpc, input logic [15:0] opc);
        rst_i = rst; fetch_valid_i = fv; icache_valid_i = iv; icache_instr_i = instr;
        branch_valid_i = bv; fetch_branch_pc_i = bpc; opcode_pc_i = opc;
    endtask

    initial begin
        branch_type_oi = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000);

        //   rst fv iv instr     bv bpc       opc       icpc      rd v  fpc       instr
        // sequential fetch
        add(0, 1, 1, 16'hA55A, 0, 16'h0000, 16'h0000, 16'h0000, 1, 1, 16'h0000, 16'hA55A);
        add(0, 1, 1, 16'h5AA5, 0, 16'h0000, 16'h0000, 16'h0002, 1, 1, 16'h0002, 16'h5AA5);
        add(0, 1, 1, 16'h1234, 0, 16'h0000, 16'h0000, 16'h0004, 1, 1, 16'h0004, 16'h1234);
        // branch miss allocates 1002->2000
        add(0, 1, 1, 16'h0000, 1, 16'h2000, 16'h1002, 16'h0006, 0, 0, 16'h0004, 16'h0000);
        add(0, 1, 1, 16'hCAFE, 0, 16'h0000, 16'h0000, 16'h2000, 1, 1, 16'h2000, 16'hCAFE);
        // BTB hit overrides supplied target 3000
        add(0, 1, 1, 16'h0000, 1, 16'h3000, 16'h1002, 16'h2002, 0, 0, 16'h2000, 16'h0000);
        add(0, 1, 1, 16'hCAFE, 0, 16'h0000, 16'h0000, 16'h2000, 1, 1, 16'h2000, 16'hCAFE);
        add(0, 1, 1, 16'h0BAD, 0, 16'h0000, 16'h0000, 16'h2002, 1, 1, 16'h2002, 16'h0BAD);
        // idle
        add(0, 0, 1, 16'h9999, 0, 16'h0000, 16'h0000, 16'h2004, 0, 0, 16'h2002, 16'h0000);
        add(0, 0, 0, 16'h9999, 0, 16'h0000, 16'h0000, 16'h2004, 0, 0, 16'h2002, 16'h0000);
        // reset mid-stream, then former BTB key must miss
        add(1, 1, 1, 16'h1111, 0, 16'h0000, 16'h0000, 16'h2004, 0, 0, 16'h0000, 16'h0000);
        add(0, 1, 1, 16'h0000, 1, 16'h4444, 16'h1002, 16'h0000, 0, 0, 16'h0000, 16'h0000);
        add(0, 1, 1, 16'h7777, 0, 16'h0000, 16'h0000, 16'h4444, 1, 1, 16'h4444, 16'h7777);
        // FIFO replacement
        add(1, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h4446, 0, 0, 16'h0000, 16'h0000);
        for (int i = 0; i < 8; i++) begin
            add(0, 0, 0, 16'h0000, 1, 16'(16'h4000 + i * 16'h0100), 16'(16'h3000 + i * 16'h0100),
                (i == 0) ? 16'h0000 : 16'(16'h4000 + (i - 1) * 16'h0100), 0, 0, 16'h0000, 16'h0000);
        end
        add(0, 0, 0, 16'h0000, 1, 16'h8000, 16'h7000, 16'h4700, 0, 0, 16'h0000, 16'h0000);
        add(0, 0, 0, 16'h0000, 1, 16'h9000, 16'h7000, 16'h8000, 0, 0, 16'h0000, 16'h0000);
        add(0, 0, 0, 16'h0000, 1, 16'h5555, 16'h3000, 16'h8000, 0, 0, 16'h0000, 16'h0000);
        add(0, 1, 1, 16'hBABE, 0, 16'h0000, 16'h0000, 16'h5555, 1, 1, 16'h5555, 16'hBABE);
        // hit on 7000 takes us back to 8000, then cache miss at 8002
        add(0, 1, 1, 16'h0000, 1, 16'h0000, 16'h7000, 16'h5557, 0, 0, 16'h5555, 16'h0000);
        add(0, 1, 1, 16'h1357, 0, 16'h0000, 16'h0000, 16'h8000, 1, 1, 16'h8000, 16'h1357);
        add(0, 1, 0, 16'hDEAD, 0, 16'h0000, 16'h0000, 16'h8002, 1, 0, 16'h8002, 16'h0000);
        add(0, 1, 1, 16'hFACE, 0, 16'h0000, 16'h0000, 16'h8002, 1, 1, 16'h8002, 16'hFACE);
        add(0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h8004, 0, 0, 16'h8002, 16'h0000);
        // 3100 was evicted by the 3000 re-allocation
        add(0, 0, 0, 16'h0000, 1, 16'h6000, 16'h3100, 16'h8004, 0, 0, 16'h8002, 16'h0000);
        add(0, 1, 1, 16'h2468, 0, 16'h0000, 16'h0000, 16'h6000, 1, 1, 16'h6000, 16'h2468);
        // PC wrap at FFFE
        add(0, 0, 0, 16'h0000, 1, 16'hFFFE, 16'h0100, 16'h6002, 0, 0, 16'h6000, 16'h0000);
        add(0, 1, 1, 16'hAAAA, 0, 16'h0000, 16'h0000, 16'hFFFE, 1, 1, 16'hFFFE, 16'hAAAA);
        add(0, 1, 1, 16'hBBBB, 0, 16'h0000, 16'h0000, 16'h0000, 1, 1, 16'h0000, 16'hBBBB);
        // back-to-back branches: the last one wins
        add(0, 1, 1, 16'h0000, 1, 16'h1230, 16'h0200, 16'h0002, 0, 0, 16'h0000, 16'h0000);
        add(0, 1, 1, 16'h0000, 1, 16'h2340, 16'h0300, 16'h1230, 0, 0, 16'h0000, 16'h0000);
        add(0, 1, 1, 16'hCCCC, 0, 16'h0000, 16'h0000, 16'h2340, 1, 1, 16'h2340, 16'hCCCC);

        // reset state
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("reset_icache_pc", 0, icache_pc_o, 16'h0000);
        chk("reset_icache_rd", 0, {15'd0, icache_rd_o}, 16'h0000);
        chk("reset_valid", 0, {15'd0, instr_valid_o}, 16'h0000);
        chk("reset_fetch_pc", 0, fetch_pc_o, 16'h0000);
        chk("reset_fetch_instr", 0, fetch_instr_o, 16'h0000);

        foreach (vecs[k]) begin
            @(negedge clk_i);
            drive(vecs[k].rst, vecs[k].fv, vecs[k].iv, vecs[k].instr,
                  vecs[k].bv, vecs[k].bpc, vecs[k].opc);
            #1;
            chk("icache_pc", k, icache_pc_o, vecs[k].exp_icpc);
            chk("icache_rd", k, {15'd0, icache_rd_o}, {15'd0, vecs[k].exp_rd});
            @(posedge clk_i);
            #1;
            chk("instr_valid", k, {15'd0, instr_valid_o}, {15'd0, vecs[k].exp_v});
            chk("fetch_pc", k, fetch_pc_o, vecs[k].exp_fpc);
            if (vecs[k].exp_v)
                chk("fetch_instr", k, fetch_instr_o, vecs[k].exp_instr);
        end

        // reset beats a simultaneous branch: no redirect and no allocation
        @(negedge clk_i);
        drive(1'b1, 1'b1, 1'b1, 16'h0000, 1'b1, 16'h7770, 16'h0500);
        @(negedge clk_i);
        chk("rst_vs_branch_pc", 0, icache_pc_o, 16'h0000);
        chk("rst_vs_branch_valid", 0, {15'd0, instr_valid_o}, 16'h0000);
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h1110, 16'h0500);
        @(negedge clk_i);
        chk("rst_vs_branch_miss", 0, icache_pc_o, 16'h1110);
        drive(1'b0, 1'b1, 1'b1, 16'h4321, 1'b0, 16'h0000, 16'h0000);
        @(negedge clk_i);
        chk("rst_vs_branch_fpc", 0, fetch_pc_o, 16'h1110);
        chk("rst_vs_branch_instr", 0, fetch_instr_o, 16'h4321);
        chk("rst_vs_branch_next", 0, icache_pc_o, 16'h1112);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
